// File: rtl/press_classifier_pkg.sv
// Shared types and default constants for the press_classifier block.
package press_classifier_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PRESSED = ST_PRESSED,
    LONG    = ST_LONG
  } press_state_t;

  localparam int DB_LEN_DEF       = 4;
  localparam int LONG_TICKS_DEF   = 200;
  localparam int REPEAT_TICKS_DEF = 25;

endpackage

// File: rtl/press_classifier_if.sv
// Button input and classified-press output bundle; the classifier is the slave.
interface press_classifier_if;

  logic tick;
  logic pb_raw;
  logic pb_clean;
  logic short_pulse;
  logic long_pulse;
  logic held_long;
  logic repeat_pulse;

  modport master (
    output tick, pb_raw,
    input  pb_clean, short_pulse, long_pulse, held_long, repeat_pulse
  );

  modport slave (
    input  tick, pb_raw,
    output pb_clean, short_pulse, long_pulse, held_long, repeat_pulse
  );

endinterface

// File: rtl/press_classifier_tick_debouncer.sv
// Two-flop synchronizer plus tick-sampled shift register producing a debounced level.
module tick_debouncer
  import press_classifier_pkg::*;
#(
  parameter int DB_LEN = DB_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pb_raw,
  output logic pb_clean
);

  logic              sync1;
  logic              sync2;
  logic [DB_LEN-1:0] shreg;
  logic [DB_LEN-1:0] shreg_next;

  // Level decision looks at the register including this tick's sample.
  always_comb begin
    shreg_next = {shreg[DB_LEN-2:0], sync2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      shreg    <= '0;
      pb_clean <= 1'b0;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
      if (tick) begin
        shreg <= shreg_next;
        if (&shreg_next) begin
          pb_clean <= 1'b1;
        end else if (~|shreg_next) begin
          pb_clean <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/press_classifier.sv
// Debounced push button classified into short/long press pulses for the stopwatch FSM.
// Optional auto-repeat while held long is enabled by defining PRESS_REPEAT_EN.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int DB_LEN       = DB_LEN_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input logic               clk,
  input logic               rst,
  press_classifier_if.slave bus
);

  localparam int                HOLD_W    = $clog2(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS);

  if (DB_LEN < 2 || DB_LEN > 16 || LONG_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("press_classifier: parameter out of range");
  end

  press_state_t      state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_inc;
  logic              clean;
  logic              short_q;
  logic              long_q;
  logic              held_q;
  logic              long_hit;

  tick_debouncer #(
    .DB_LEN (DB_LEN)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.tick),
    .pb_raw   (bus.pb_raw),
    .pb_clean (clean)
  );

  always_comb begin
    hold_inc = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
  end

  // Release is checked first in PRESSED, so a same-cycle threshold never fires.
  assign long_hit = (state == PRESSED) && clean && bus.tick && (hold_inc == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (clean) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (!clean) begin
            short_q <= 1'b1;
            state   <= IDLE;
          end else if (bus.tick) begin
            hold_cnt <= hold_inc;
            if (long_hit) begin
              long_q <= 1'b1;
              held_q <= 1'b1;
              state  <= LONG;
            end
          end
        end
        LONG: begin
          if (!clean) begin
            held_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          held_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef PRESS_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_inc;
  logic             rep_q;

  assign rep_inc = rep_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
      rep_q   <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (long_hit) begin
        rep_cnt <= '0;
      end else if (state == LONG && clean && bus.tick) begin
        if (rep_inc == REP_LAST) begin
          rep_q   <= 1'b1;
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_inc;
        end
      end
    end
  end

  assign bus.repeat_pulse = rep_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

  assign bus.pb_clean    = clean;
  assign bus.short_pulse = short_q;
  assign bus.long_pulse  = long_q;
  assign bus.held_long   = held_q;

  pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({short_q, long_q, bus.repeat_pulse}));

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier against a press-level reference model.
module tb_press_classifier;

  localparam int DB = 4;
  localparam int LT = 10;
  localparam int RT = 3;
`ifdef PRESS_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  press_classifier_if bus ();

  press_classifier #(
    .DB_LEN       (DB),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors     = 0;
  int checks     = 0;
  int tick_mode  = 0;
  int tick_phase = 0;

  // Reference model: raw history, last DB tick samples, and press duration in ticks.
  bit raw_hist[$];
  bit samp[$];
  bit m_clean = 0;
  bit m_in    = 0;
  bit m_long  = 0;
  int m_ticks = 0;
  bit e_short = 0;
  bit e_long  = 0;
  bit e_rep   = 0;

  always @(posedge clk or posedge rst) begin : model
    bit synced, c, ones, zeros;
    if (rst) begin
      raw_hist.delete();
      samp.delete();
      m_clean = 0; m_in = 0; m_long = 0; m_ticks = 0;
      e_short = 0; e_long = 0; e_rep = 0;
    end else begin
      c = m_clean;
      raw_hist.push_back(bus.pb_raw);
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());
      synced = (raw_hist.size() == 3) ? raw_hist[0] : 1'b0;
      e_short = 0; e_long = 0; e_rep = 0;
      if (!m_in) begin
        if (c) begin m_in = 1; m_long = 0; m_ticks = 0; end
      end else if (!c) begin
        e_short = !m_long;
        m_in = 0; m_long = 0;
      end else if (bus.tick) begin
        m_ticks++;
        if (!m_long && m_ticks == LT) begin
          e_long = 1; m_long = 1;
        end else if (m_long && REP_EN && ((m_ticks - LT) % RT == 0)) begin
          e_rep = 1;
        end
      end
      if (bus.tick) begin
        samp.push_back(synced);
        if (samp.size() > DB) void'(samp.pop_front());
        ones  = (samp.size() == DB);
        zeros = 1;
        foreach (samp[k]) begin
          if (samp[k]) zeros = 0; else ones = 0;
        end
        if (ones) m_clean = 1;
        else if (zeros) m_clean = 0;
      end
    end
  end

  function automatic logic [4:0] dut_outs();
    return {bus.pb_clean, bus.short_pulse, bus.long_pulse, bus.held_long, bus.repeat_pulse};
  endfunction

  function automatic logic [4:0] model_outs();
    return {m_clean, e_short, e_long, m_in && m_long, e_rep};
  endfunction

  task automatic cycle();
    case (tick_mode)
      0: bus.tick = 1'b1;
      1: begin bus.tick = (tick_phase % 4 == 0); tick_phase++; end
      default: bus.tick = ($urandom_range(0, 1) == 1);
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int found, early;
    tick_mode = 0;
    rst = 1'b1; bus.pb_raw = 1'b0; bus.tick = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_outs() !== 5'b0) begin
      errors++; $display("FAIL reset_init: outs=%b expected=%b", dut_outs(), 5'b0);
    end
    rst = 1'b0;
    bus.pb_raw = 1'b1;
    for (int i = 0; i < 40 && !(m_in && m_ticks == 5); i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL reset_press cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
    end
    checks++;
    if (!(m_in && m_ticks == 5)) begin
      errors++; $display("FAIL reset_reach_hold5: ticks=%0d required=5 (timeout)", m_ticks);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_outs() !== 5'b0) begin
      errors++; $display("FAIL reset_async: outs=%b expected=%b", dut_outs(), 5'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    found = -1; early = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL reset_rehold cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
      if (found < 0) begin
        if (bus.pb_clean) found = i;
        else if (bus.short_pulse | bus.long_pulse | bus.repeat_pulse | bus.held_long) early++;
      end
    end
    checks++;
    if (found != DB + 2) begin
      errors++; $display("FAIL reset_reclean_latency: got=%0d required=%0d", found, DB + 2);
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL reset_early_pulse: got=%0d required=0", early);
    end
    bus.pb_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL reset_release cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_glitch();
    int nclean = 0;
    for (int i = 0; i < 18; i++) begin
      bus.pb_raw = (i < 3);
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL glitch cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
      if (bus.pb_clean | bus.short_pulse | bus.long_pulse) nclean++;
    end
    checks++;
    if (nclean != 0) begin
      errors++; $display("FAIL glitch_reject: active_cycles=%0d required=0", nclean);
    end
  endtask

  task automatic test_short_press();
    int nshort = 0, nlong = 0, at = -1;
    bus.pb_raw = 1'b1;
    repeat (8) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL short_hold: outs=%b expected=%b", dut_outs(), model_outs());
      end
      if (bus.long_pulse) nlong++;
    end
    bus.pb_raw = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL short_release cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
      if (bus.short_pulse) begin nshort++; at = i; end
      if (bus.long_pulse) nlong++;
    end
    checks++;
    if (nshort != 1) begin errors++; $display("FAIL short_count: got=%0d required=1", nshort); end
    checks++;
    if (at != DB + 3) begin errors++; $display("FAIL short_latency: got=%0d required=%0d", at, DB + 3); end
    checks++;
    if (nlong != 0) begin errors++; $display("FAIL short_no_long: got=%0d required=0", nlong); end
  endtask

  task automatic test_long_press();
    int nlong = 0, nshort = 0, at = -1;
    bus.pb_raw = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL long_hold cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
      if (bus.long_pulse) begin nlong++; at = i; end
    end
    checks++;
    if (nlong != 1) begin errors++; $display("FAIL long_count: got=%0d required=1", nlong); end
    checks++;
    if (at != DB + 3 + LT) begin errors++; $display("FAIL long_latency: got=%0d required=%0d", at, DB + 3 + LT); end
    checks++;
    if (bus.held_long !== 1'b1) begin errors++; $display("FAIL long_held: got=%b required=1", bus.held_long); end
    bus.pb_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL long_release cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
      if (bus.short_pulse) nshort++;
    end
    checks++;
    if (nshort != 0) begin errors++; $display("FAIL long_no_short: got=%0d required=0", nshort); end
    checks++;
    if (bus.held_long !== 1'b0) begin errors++; $display("FAIL long_held_clear: got=%b required=0", bus.held_long); end
  endtask

  // Raw high for LT clocks makes release land on the threshold tick; LT+1 just crosses it.
  task automatic test_boundary();
    for (int k = 0; k < 2; k++) begin
      int hl, nshort, nlong;
      hl = LT + k; nshort = 0; nlong = 0;
      for (int i = 0; i < hl + 20; i++) begin
        bus.pb_raw = (i < hl);
        cycle();
        checks++;
        if (dut_outs() !== model_outs()) begin
          errors++; $display("FAIL boundary_%0d cyc %0d: outs=%b expected=%b", hl, i, dut_outs(), model_outs());
        end
        if (bus.short_pulse) nshort++;
        if (bus.long_pulse) nlong++;
      end
      checks++;
      if (nshort != ((hl <= LT) ? 1 : 0)) begin
        errors++; $display("FAIL boundary_%0d_short: got=%0d required=%0d", hl, nshort, (hl <= LT) ? 1 : 0);
      end
      checks++;
      if (nlong != ((hl > LT) ? 1 : 0)) begin
        errors++; $display("FAIL boundary_%0d_long: got=%0d required=%0d", hl, nlong, (hl > LT) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    bit lvl = 0;
    tick_mode = 2;
    for (int s = 0; s < 40; s++) begin
      int len;
      lvl = !lvl;
      len = $urandom_range(1, 30);
      bus.pb_raw = lvl;
      for (int i = 0; i < len; i++) begin
        cycle();
        checks++;
        if (dut_outs() !== model_outs()) begin
          errors++; $display("FAIL random seg %0d cyc %0d: outs=%b expected=%b", s, i, dut_outs(), model_outs());
        end
        checks++;
        if (32'(bus.short_pulse) + 32'(bus.long_pulse) + 32'(bus.repeat_pulse) > 1) begin
          errors++; $display("FAIL random_exclusive: pulses=%b%b%b required at most one",
                             bus.short_pulse, bus.long_pulse, bus.repeat_pulse);
        end
      end
    end
    tick_mode = 0;
    bus.pb_raw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL random_settle cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_slow_tick_repeat();
    int t_long = -1, t_prev = -1, nrep = 0, stray = 0;
    tick_mode = 1; tick_phase = 0;
    bus.pb_raw = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL slow_hold cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
      if (bus.long_pulse) begin t_long = i; t_prev = i; end
      if (bus.repeat_pulse) begin
        nrep++;
        checks++;
        if (i - t_prev != 4 * RT) begin
          errors++; $display("FAIL slow_repeat_gap: got=%0d required=%0d", i - t_prev, 4 * RT);
        end
        t_prev = i;
      end
    end
    checks++;
    if (t_long < 0) begin errors++; $display("FAIL slow_long_seen: got=none required=one (timeout)"); end
`ifdef PRESS_REPEAT_EN
    checks++;
    if (nrep < 1) begin errors++; $display("FAIL slow_repeat_count: got=%0d required>=1", nrep); end
`else
    checks++;
    if (nrep != 0) begin errors++; $display("FAIL slow_repeat_disabled: got=%0d required=0", nrep); end
`endif
    bus.pb_raw = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++; $display("FAIL slow_release cyc %0d: outs=%b expected=%b", i, dut_outs(), model_outs());
      end
      if (bus.repeat_pulse && !bus.held_long) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL slow_repeat_after_release: got=%0d required=0", stray); end
    tick_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.pb_raw = 1'b0;
    bus.tick = 1'b1;
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_boundary();
    test_random();
    test_slow_tick_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Conditions one raw push button and classifies each press as short or long, emitting one-clock pulses for the stopwatch control FSM (pause/start, lap/reset).
- Sits directly upstream of the FSM and replaces a separate debounce plus one-pulse pair per button.
- Runs on the system clock and samples on an external tick strobe.

Parameters:
- DB_LEN, 4, number of consecutive equal tick samples needed to change the debounced level (2..16).
- LONG_TICKS, 200, held-tick count at which a press becomes long (>= 2).
- REPEAT_TICKS, 25, tick period of auto-repeat pulses; used only with PRESS_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-clk sampling strobe (e.g. 100 Hz); tie to 1 for per-clock sampling.
- pb_raw  input  1  raw, asynchronous button level, active-high.
- pb_clean  output  1  debounced level.
- short_pulse  output  1  one-clk pulse on release of a press shorter than LONG_TICKS.
- long_pulse  output  1  one-clk pulse when a held press reaches LONG_TICKS.
- held_long  output  1  level; high from long_pulse until release.
- repeat_pulse  output  1  one-clk auto-repeat pulse; constant 0 without PRESS_REPEAT_EN.

Behaviour:
- Reset state: all outputs 0, synchronizer and shift register cleared to 0, FSM in IDLE, counters 0. Reset mid-press discards that press. A button still held after reset deasserts is treated as a new press once DB_LEN ticks have been sampled.
- Synchronizer: 2-flop synchronizer on pb_raw, clocked every clk.
- Debounce: on each clk with tick=1, shift the synchronized bit into a DB_LEN-bit register.
  - pb_clean is registered: set to 1 when all bits are 1, cleared to 0 when all bits are 0, otherwise held.
  - pb_clean is only evaluated on tick cycles.
- FSM (states IDLE, PRESSED, LONG) evaluates every clk against the current pb_clean. All pulse outputs are registered and high for exactly one clk.
- IDLE:
  - pb_clean=1: go to PRESSED, hold_cnt <= 0.
- PRESSED:
  - pb_clean=0: assert short_pulse next clk, go to IDLE.
  - Otherwise, on tick, hold_cnt increments.
  - When the incremented value equals LONG_TICKS: assert long_pulse, set held_long, go to LONG, rep_cnt <= 0.
  - If release and threshold occur in the same cycle, release wins: short_pulse, no long_pulse.
- LONG:
  - pb_clean=0: clear held_long, go to IDLE. No short_pulse.
  - With the feature enabled, auto-repeat per Optional Feature.
- Counters:
  - hold_cnt width is $clog2(LONG_TICKS+1) and saturates; it never wraps.
  - rep_cnt width is $clog2(REPEAT_TICKS+1).
- Mutual exclusion: short_pulse, long_pulse and repeat_pulse are never high in the same cycle.
- Latency, raw rising edge to PRESSED: 2 clk synchronizer + DB_LEN ticks + 1 clk.
- A bounce shorter than DB_LEN consecutive ticks never changes pb_clean.

Optional Feature:
- Macro: PRESS_REPEAT_EN.
- Defined: in LONG, rep_cnt increments on tick. On reaching REPEAT_TICKS, repeat_pulse is high one clk and rep_cnt resets to 0. The first repeat pulse comes REPEAT_TICKS ticks after long_pulse. Release stops repeats immediately.
- Undefined: rep_cnt logic is removed and repeat_pulse is tied to 0.

Decomposition:
- Shared package holds:
  - state typedef press_state_t {IDLE, PRESSED, LONG}, 2-bit encoding.
  - Default constants DB_LEN_DEF=4, LONG_TICKS_DEF=200, REPEAT_TICKS_DEF=25.
- One sub-module, tick_debouncer: synchronizer, shift register and pb_clean, with ports clk, rst, tick, pb_raw, pb_clean.
- The FSM and counters stay in press_classifier.

Test Plan (DB_LEN=4, LONG_TICKS=10, REPEAT_TICKS=3, tick every clk unless stated):
- Reset: assert rst mid-press at hold_cnt=5 -> all outputs 0 immediately. After release of rst with pb_raw still 1 -> PRESSED reached 7 clks later, no pulse of any kind before that.
- Glitch rejection: pb_raw 1 for 3 clks, then 0 -> pb_clean stays 0, no pulses.
- Short press: pb_raw 1 for 8 clks, then 0 -> exactly one short_pulse about 7 clks after the fall; long_pulse never asserted.
- Long press with no release: pb_raw held 1 -> long_pulse one clk after hold_cnt reaches 10; held_long stays 1; no short_pulse on the later release.
- Boundary: release timed so pb_clean falls in the same cycle hold_cnt would reach 10 -> short_pulse only.
- Slow tick (tick every 4th clk) with PRESS_REPEAT_EN defined and a long hold -> repeat_pulse every 12 clks after long_pulse, stopping on release. With the macro undefined -> repeat_pulse always 0.
